// File: rtl/frame_strobe_sequencer.sv
// Turns a header/data word stream into FrameData plus a one-cycle one-hot FrameStrobe,
// with FrameData set up one cycle before the strobe and held one cycle after it.
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int IDX_W           = 5
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FrameBitsPerRow-1:0] s_data,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err_sticky,
  input  logic                       err_clr,
  output logic [15:0]                frames_written,
  output logic [2:0]                 state_dbg
);

  // Handshake: a word transfers on a rising CLK edge where s_valid && s_ready.
  // s_ready depends on state only; s_valid may be raised or dropped at any time.

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam logic [IDX_W:0]           IDX_LIMIT  = (IDX_W+1)'(MaxFramesPerCol);
  localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [FrameBitsPerRow-1:0]   frame_data_q, frame_data_d;
  logic [MaxFramesPerCol-1:0]   frame_strobe_q, frame_strobe_d;
  logic                         err_sticky_q, err_sticky_d;
  logic [15:0]                  frames_written_q, frames_written_d;

  logic                         accept;
  logic [3:0]                   hdr_op;
  logic [IDX_W-1:0]             hdr_idx;
  logic                         hdr_ok;
  logic                         err_set;

  assign s_ready = (state_q == ST_IDLE) || (state_q == ST_DATA);
  assign accept  = s_valid && s_ready;
  assign hdr_op  = s_data[FrameBitsPerRow-1 -: 4];
  assign hdr_idx = s_data[IDX_W-1:0];
  assign hdr_ok  = (hdr_op == 4'hA) && ({1'b0, hdr_idx} < IDX_LIMIT);

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    frame_data_d     = frame_data_q;
    frame_strobe_d   = '0;
    frames_written_d = frames_written_q;
    err_set          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hdr_ok) begin
            idx_d   = hdr_idx;
            state_d = ST_DATA;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          frame_data_d = s_data;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Strobe is registered, so it is loaded here to be high during STROBE.
        frame_strobe_d = STROBE_ONE << idx_q;
        state_d        = ST_STROBE;
      end
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        frames_written_d = frames_written_q + 16'd1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new error wins over a clear in the same cycle.
    if (err_set)      err_sticky_d = 1'b1;
    else if (err_clr) err_sticky_d = 1'b0;
    else              err_sticky_d = err_sticky_q;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      frame_data_q     <= '0;
      frame_strobe_q   <= '0;
      err_sticky_q     <= 1'b0;
      frames_written_q <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      frame_data_q     <= frame_data_d;
      frame_strobe_q   <= frame_strobe_d;
      err_sticky_q     <= err_sticky_d;
      frames_written_q <= frames_written_d;
    end
  end

  assign FrameData      = frame_data_q;
  assign FrameStrobe    = frame_strobe_q;
  assign busy           = (state_q != ST_IDLE);
  assign err_sticky     = err_sticky_q;
  assign frames_written = frames_written_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Bench for frame_strobe_sequencer: directed steps plus random words, checked against a
// word-stream model (header/data parsing, expected strobe queue, counters).
module tb_frame_strobe_sequencer;

  localparam int M = 20;
  localparam int W = 32;

  logic          CLK;
  logic          resetn;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic [W-1:0]  FrameData;
  logic [M-1:0]  FrameStrobe;
  logic          busy;
  logic          err_sticky;
  logic          err_clr;
  logic [15:0]   frames_written;
  logic [2:0]    state_dbg;

  frame_strobe_sequencer #(
    .MaxFramesPerCol(M),
    .FrameBitsPerRow(W),
    .IDX_W(5)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .err_sticky(err_sticky),
    .err_clr(err_clr),
    .frames_written(frames_written),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [W-1:0] exp_q[$];
  int           exp_idx_q[$];
  logic         m_expect_hdr;
  int           m_idx;
  logic         m_err;
  logic [15:0]  m_fw;
  logic [W-1:0] m_last_data;

  // monitor state
  logic         mon_en;
  logic         spacing_mode;
  logic         hold_pending;
  logic [W-1:0] hold_data;
  logic [W-1:0] prev_fd;
  int           cyc;
  int           last_strobe_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_idx_q.delete();
    m_expect_hdr = 1'b1;
    m_idx        = 0;
    m_err        = 1'b0;
    m_fw         = 16'd0;
    m_last_data  = '0;
    hold_pending = 1'b0;
  endtask

  // One accepted word, interpreted by the stream rules.
  task automatic model_accept(input logic [W-1:0] w);
    logic [4:0] f_idx;
    logic       bad;
    f_idx = w[4:0];
    bad   = 1'b0;
    if (m_expect_hdr) begin
      if (w[31:28] == 4'hA && int'(f_idx) < M) begin
        m_idx        = int'(f_idx);
        m_expect_hdr = 1'b0;
      end else begin
        bad = 1'b1;
      end
    end else begin
      exp_q.push_back(w);
      exp_idx_q.push_back(m_idx);
      m_last_data  = w;
      m_fw         = m_fw + 16'd1;
      m_expect_hdr = 1'b1;
    end
    if (bad)          m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic send_word(input logic [W-1:0] w);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      check("ready_timeout", 64'(n), 64'd0);
    end else begin
      @(posedge CLK);
      model_accept(w);
    end
    @(negedge CLK);
    s_valid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic send_frame(input int idx, input logic [W-1:0] d, input int max_gap);
    repeat ($urandom_range(max_gap, 0)) @(negedge CLK);
    send_word(32'hA000_0000 | 32'(idx));
    repeat ($urandom_range(max_gap, 0)) @(negedge CLK);
    send_word(d);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge CLK);
    m_err = 1'b0;
    @(negedge CLK);
    err_clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_drain"}, 64'(n < 60), 64'd1);
    check({tag, "_frames"}, 64'(frames_written), 64'(m_fw));
    check({tag, "_err"}, 64'(err_sticky), 64'(m_err));
    check({tag, "_data"}, 64'(FrameData), 64'(m_last_data));
    check({tag, "_ready"}, 64'(s_ready), 64'd1);
  endtask

  // monitor: strobe shape, setup/hold of FrameData, spacing
  initial begin
    logic [M-1:0] one;
    logic [W-1:0] d;
    int           i;
    one             = 1;
    cyc             = 0;
    last_strobe_cyc = -1;
    prev_fd         = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (resetn && mon_en) begin
        check("strobe_onehot0", 64'($onehot0(FrameStrobe)), 64'd1);
        if (hold_pending) begin
          check("hold_strobe", 64'(FrameStrobe), 64'd0);
          check("hold_data", 64'(FrameData), 64'(hold_data));
          hold_pending = 1'b0;
        end
        if (FrameStrobe != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 64'(FrameStrobe), 64'd0);
          end else begin
            d = exp_q.pop_front();
            i = exp_idx_q.pop_front();
            check("strobe_idx", 64'(FrameStrobe), 64'(one << i));
            check("strobe_data", 64'(FrameData), 64'(d));
            check("setup_data", 64'(prev_fd), 64'(d));
            check("strobe_ready", 64'(s_ready), 64'd0);
            check("strobe_busy", 64'(busy), 64'd1);
            if (spacing_mode && last_strobe_cyc >= 0)
              check("strobe_spacing", 64'(cyc - last_strobe_cyc), 64'd5);
            last_strobe_cyc = cyc;
            hold_pending    = 1'b1;
            hold_data       = d;
          end
        end
      end
      prev_fd = FrameData;
    end
  end

  initial begin
    logic [W-1:0] w;
    logic [4:0]   r_idx;
    resetn       = 1'b1;
    s_valid      = 1'b0;
    s_data       = '0;
    err_clr      = 1'b0;
    mon_en       = 1'b0;
    spacing_mode = 1'b0;
    model_reset();
    #3 resetn = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_strobe", 64'(FrameStrobe), 64'd0);
    check("rst_data", 64'(FrameData), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_sticky), 64'd0);
    check("rst_frames", 64'(frames_written), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd1);
    resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);

    // single write
    send_frame(3, 32'hDEADBEEF, 0);
    wait_idle("single");
    check("single_frames_is_1", 64'(frames_written), 64'd1);

    // boundary indices
    send_frame(0, 32'h0000_0001, 0);
    send_frame(19, 32'h1919_1919, 0);
    wait_idle("idx_edge");
    send_word(32'hA000_0014);
    wait_idle("idx20");
    check("idx20_err_set", 64'(err_sticky), 64'd1);
    pulse_clr();
    check("clr_err", 64'(err_sticky), 64'd0);

    // bad opcode, following word is a header
    send_word(32'h5000_0002);
    check("badop_err", 64'(err_sticky), 64'd1);
    send_frame(2, 32'hCAFE_0002, 0);
    wait_idle("after_badop");
    err_clr = 1'b1;
    send_word(32'h7000_0001);
    check("clr_vs_set", 64'(err_sticky), 64'd1);
    pulse_clr();

    // async reset in the middle of a strobe
    send_word(32'h5000_0000);
    send_word(32'hA000_0005);
    send_word(32'h5555_AAAA);
    @(posedge CLK);
    #1;
    check("pre_rst_strobe", 64'(FrameStrobe), 64'h20);
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_strobe", 64'(FrameStrobe), 64'd0);
    check("midrst_data", 64'(FrameData), 64'd0);
    check("midrst_err", 64'(err_sticky), 64'd0);
    check("midrst_frames", 64'(frames_written), 64'd0);
    check("midrst_ready", 64'(s_ready), 64'd1);
    model_reset();
    @(negedge CLK);
    resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);

    // reset while waiting for data: next word is a header again
    send_word(32'hA000_0004);
    mon_en = 1'b0;
    resetn = 1'b0;
    model_reset();
    @(negedge CLK);
    resetn = 1'b1;
    mon_en = 1'b1;
    send_word(32'h1234_5678);
    wait_idle("rst_in_data");

    // streaming, s_valid kept high
    spacing_mode    = 1'b1;
    last_strobe_cyc = -1;
    send_frame(1, 32'h1111_0001, 0);
    send_frame(2, 32'h2222_0002, 0);
    send_frame(3, 32'h3333_0003, 0);
    wait_idle("stream");
    spacing_mode = 1'b0;

    // same frames with random gaps
    for (int k = 1; k <= 3; k++) send_frame(k, 32'hABCD_0000 | 32'(k), 3);
    wait_idle("stream_gaps");

    // random word stream
    for (int k = 0; k < 60; k++) begin
      r_idx = 5'($urandom_range(31, 0));
      case ($urandom_range(9, 0))
        0: w = {4'($urandom_range(9, 0)), 23'($urandom), r_idx};
        1: w = {4'hA, 23'($urandom), 5'($urandom_range(31, 20))};
        default: w = {4'hA, 23'($urandom), 5'($urandom_range(19, 0))};
      endcase
      repeat ($urandom_range(2, 0)) @(negedge CLK);
      if ($urandom_range(7, 0) == 0) err_clr = 1'b1;
      send_word(w);
      if (m_expect_hdr == 1'b0) begin
        repeat ($urandom_range(2, 0)) @(negedge CLK);
        send_word($urandom);
      end
      if ((k % 10) == 9) wait_idle("random");
    end
    wait_idle("random_end");

    // counter wrap via preload
    force dut.frames_written_q = 16'hFFFF;
    @(negedge CLK);
    release dut.frames_written_q;
    m_fw = 16'hFFFF;
    @(negedge CLK);
    check("wrap_preload", 64'(frames_written), 64'hFFFF);
    send_frame(7, 32'h7777_7777, 0);
    wait_idle("wrap");
    check("wrap_zero", 64'(frames_written), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL global_timeout: observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
